// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: PC link, instruction-memory read port and decoder handshake.
// master = fetch unit, slave = the PC / memory / decoder side.
interface instr_fetch_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  pc_inc_no;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rd_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic [DATA_WIDTH-1:0] ir_o;
  logic [ADDR_WIDTH-1:0] ir_addr_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    input  pc_i, mem_ack_i, mem_data_i, ready_i,
    output pc_inc_no, mem_addr_o, mem_rd_o, ir_o, ir_addr_o, valid_o
  );

  modport slave (
    output pc_i, mem_ack_i, mem_data_i, ready_i,
    input  pc_inc_no, mem_addr_o, mem_rd_o, ir_o, ir_addr_o, valid_o
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC -> memory read -> IR with valid/ready to the decoder.
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic          flush_i,
  output logic          fault_o,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ir_addr_q, ir_addr_d;
  logic                  valid_q, valid_d;
  logic                  inc_n_q, inc_n_d;
  logic                  start_ok;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;

  // A latched fault blocks all further fetches until reset.
  assign start_ok = enable_i & ~fault_q;
  assign fault_o  = fault_q;
`else
  assign start_ok = enable_i;
  assign fault_o  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    ir_d      = ir_q;
    ir_addr_d = ir_addr_q;
    valid_d   = valid_q;
    // The increment strobe is a single-cycle pulse, so it is released by default.
    inc_n_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
    fault_d   = fault_q;
`endif

    if (flush_i) begin
      state_d = StIdle;
      valid_d = 1'b0;
      rd_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            addr_d  = bus.pc_i;
            rd_d    = 1'b1;
            state_d = StWait;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        StWait: begin
          if (bus.mem_ack_i) begin
            ir_d      = bus.mem_data_i;
            ir_addr_d = addr_q;
            valid_d   = 1'b1;
            rd_d      = 1'b0;
            inc_n_d   = 1'b0;
            state_d   = StHold;
`ifdef FETCH_TIMEOUT_EN
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            rd_d    = 1'b0;
            fault_d = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
`endif
          end
        end
        StHold: begin
          // Always return through idle so the PC increment lands before pc_i is re-sampled.
          if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      ir_q      <= '0;
      ir_addr_q <= '0;
      valid_q   <= 1'b0;
      inc_n_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      ir_q      <= ir_d;
      ir_addr_q <= ir_addr_d;
      valid_q   <= valid_d;
      inc_n_q   <= inc_n_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
`endif
    end
  end

  assign bus.mem_addr_o = addr_q;
  assign bus.mem_rd_o   = rd_q;
  assign bus.ir_o       = ir_q;
  assign bus.ir_addr_o  = ir_addr_q;
  assign bus.valid_o    = valid_q;
  assign bus.pc_inc_no  = inc_n_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits directly downstream of the program counter.
- Samples the PC output and issues a read to instruction memory, waiting for a variable-latency acknowledge.
- Latches the returned word into the instruction register and presents it to the decoder with a valid/ready handshake.
- Pulses the PC's active-low increment strobe once per fetched instruction.

Parameters:
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 16, PC / memory address width
TIMEOUT_CYCLES, 15, WAIT-state cycles before fault (used only with the optional feature)

Ports:
clk_i  input  1  system clock, all state on rising edge
reset_i  input  1  asynchronous, active-high reset
enable_i  input  1  1 = fetching permitted
flush_i  input  1  abort current fetch and discard IR (branch/redirect)
pc_i  input  ADDR_WIDTH  current PC value (PC data output)
pc_inc_no  output  1  active-low increment strobe to PC
mem_addr_o  output  ADDR_WIDTH  instruction memory address
mem_rd_o  output  1  memory read request
mem_ack_i  input  1  memory data valid this cycle
mem_data_i  input  DATA_WIDTH  memory read data
ir_o  output  DATA_WIDTH  instruction register
ir_addr_o  output  ADDR_WIDTH  address the IR was fetched from
valid_o  output  1  ir_o valid for decoder
ready_i  input  1  decoder accepts ir_o
fault_o  output  1  fetch timeout fault (optional feature)

Behaviour:
- Reset is asynchronous and active-high. While reset_i=1: state IDLE, ir_o=0, ir_addr_o=0, mem_addr_o=0, mem_rd_o=0, valid_o=0, pc_inc_no=1, fault_o=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, WAIT, HOLD.
- IDLE, enable_i=1:
  - mem_addr_o<=pc_i, mem_rd_o<=1, go to WAIT.
  - With enable_i=0, stay in IDLE.
- WAIT:
  - mem_rd_o and mem_addr_o are held stable until mem_ack_i=1 is sampled.
  - On ack: ir_o<=mem_data_i, ir_addr_o<=mem_addr_o, valid_o<=1, mem_rd_o<=0, pc_inc_no<=0, go to HOLD.
  - enable_i deasserting in WAIT does not abort the fetch.
- HOLD:
  - pc_inc_no is low for exactly the first HOLD cycle, then 1.
  - ir_o, ir_addr_o and valid_o are held until valid_o&&ready_i is sampled; then valid_o<=0 and go to IDLE.
  - HOLD always returns through IDLE. This guarantees the PC increment has landed before pc_i is re-sampled.
- Timing: with zero-wait memory (ack in the first WAIT cycle) and ready_i=1, throughput is one instruction per 3 cycles.
  - Edge E0: IDLE->WAIT.
  - Edge E1: ack->HOLD.
  - Edge E2: handshake->IDLE.
  - Edge E3: next WAIT with PC+1.
- Sustained backpressure (ready_i=0): HOLD with valid_o=1 indefinitely; no further memory reads or increments.
- flush_i=1 (priority below reset, above everything else), at the next edge:
  - valid_o<=0, mem_rd_o<=0, pc_inc_no<=1, state<=IDLE.
  - ir_o and ir_addr_o retain their values.
  - flush together with mem_ack_i: the data is discarded and no increment is issued.
  - flush in the first HOLD cycle: pc_inc_no is already low for that cycle, so the increment is not cancelled. The PC load that accompanies a redirect overrides it.
- Address width: mem_addr_o captures pc_i unmodified. Wrap from 0xFFFF to 0x0000 is the PC's concern; the fetch unit imposes no limit.
- Reset asserted mid-fetch: immediate return to reset values; an outstanding memory ack after reset is ignored (state IDLE).

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: mem_rd_o<=0, fault_o<=1, state<=IDLE.
  - fault_o is sticky until reset_i. While fault_o=1, enable_i is ignored and no further reads are issued.
  - flush_i does not clear fault_o.
- Not defined: no counter, fault_o is tied to 0, and WAIT persists until ack or flush.

Test Plan:
- Reset: hold reset_i=1 with mem_ack_i=1 and enable_i=1 -> all outputs 0, pc_inc_no=1; deassert reset -> first mem_rd_o=1 with mem_addr_o=pc_i, exactly one cycle later.
- Zero-wait fetch: pc_i=0x00A0, ack with mem_data_i=0x1234 in the first WAIT cycle, ready_i=1 -> ir_o=0x1234, ir_addr_o=0x00A0, one-cycle pc_inc_no low pulse; a model PC advancing to 0x00A1 gives next mem_addr_o=0x00A1 three cycles after the first request.
- Wait states and backpressure: ack after 4 WAIT cycles, ready_i=0 for 5 cycles -> mem_rd_o high for exactly 4 cycles; valid_o held for 5 cycles with ir_o stable; exactly one increment pulse.
- Flush with ack: flush_i=1 and mem_ack_i=1 in the same cycle -> valid_o stays 0, pc_inc_no stays 1, state IDLE; ir_o is unchanged from its previous value.
- Back-to-back: enable_i=1 with pc_i sequence 0x0000..0x0003 and data 0xA000..0xA003 -> decoder receives 4 words in order with matching ir_addr_o, and exactly 4 increment pulses.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=15: no ack -> fault_o=1 after 15 WAIT cycles, mem_rd_o=0, no further requests; fault clears only on reset_i.
